// File: rtl/qspi_pkg.sv
// Shared QSPI definitions: pop-size encodings, the byte-count helper, and
// FIFO sizing constants used by both the transmit FIFO and the CSR block.
package qspi_pkg;

   typedef enum logic [1:0] {
      SZ_1B  = 2'd0,
      SZ_2B  = 2'd1,
      SZ_4B  = 2'd2,
      SZ_RSV = 2'd3
   } tx_size_e;

   localparam int unsigned TX_FIFO_DEPTH = 16;
   localparam int unsigned TX_LVL_W      = $clog2(TX_FIFO_DEPTH) + 1;
   localparam int unsigned TX_BLVL_W     = $clog2(TX_FIFO_DEPTH) + 3;

   // Bytes moved by one pop; the reserved code behaves as a 4-byte pop.
   function automatic logic [2:0] size_bytes(input logic [1:0] sz);
      logic [2:0] n;
      case (tx_size_e'(sz))
         SZ_1B:   n = 3'd1;
         SZ_2B:   n = 3'd2;
         default: n = 3'd4;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/tx_stream_fifo_if.sv
// Bus bundle between the CSR writer / QSPI FSM (master) and tx_stream_fifo
// (slave). Carries the write port, pop port, show-ahead data, status,
// watermark threshold and error-flag controls.
interface tx_stream_fifo_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1,
   parameter int unsigned BLVL_W     = $clog2(FIFO_DEPTH) + 3
);
   logic                  fifo_tx_we;
   logic [DATA_WIDTH-1:0] fifo_tx_data;
   logic                  flush;
   logic                  tx_ren;
   logic [1:0]            tx_size;
   logic [DATA_WIDTH-1:0] tx_data;
   logic                  tx_avail;
   logic                  tx_empty;
   logic                  tx_full;
   logic [LVL_W-1:0]      tx_level;
   logic [BLVL_W-1:0]     tx_byte_level;
   logic [BLVL_W-1:0]     ae_thresh;
   logic                  tx_almost_empty;
   logic                  err_clr;
   logic                  overflow;
   logic                  underrun;

   modport master (
      output fifo_tx_we, fifo_tx_data, flush, tx_ren, tx_size, ae_thresh, err_clr,
      input  tx_data, tx_avail, tx_empty, tx_full, tx_level, tx_byte_level,
             tx_almost_empty, overflow, underrun
   );

   modport slave (
      input  fifo_tx_we, fifo_tx_data, flush, tx_ren, tx_size, ae_thresh, err_clr,
      output tx_data, tx_avail, tx_empty, tx_full, tx_level, tx_byte_level,
             tx_almost_empty, overflow, underrun
   );
endinterface

// File: rtl/tx_byte_unpack.sv
// Show-ahead window select for the transmit FIFO.
// Ports:
//   head_word  - word at the read pointer
//   next_word  - word after the read pointer (may be stale; masked by level)
//   rd_off     - bytes already consumed from head_word
//   nbytes     - bytes requested by the current pop size (1, 2 or 4)
//   byte_level - unread bytes held in the FIFO
//   data       - right-justified window, bytes past size or level forced to 0
module tx_byte_unpack #(
   parameter int unsigned BLVL_W = 7
) (
   input  logic [31:0]       head_word,
   input  logic [31:0]       next_word,
   input  logic [1:0]        rd_off,
   input  logic [2:0]        nbytes,
   input  logic [BLVL_W-1:0] byte_level,
   output logic [31:0]       data
);

   logic [63:0] pair;
   logic [31:0] win;

   always_comb begin
      pair = {next_word, head_word};
      win  = 32'(pair >> {rd_off, 3'b000});
      data = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         if ((i < 32'(nbytes)) && (i < 32'(byte_level)))
            data[8*i +: 8] = win[8*i +: 8];
      end
   end

endmodule

// File: rtl/tx_stream_fifo.sv
// QSPI transmit FIFO: 32-bit words written by the CSR block, popped 1/2/4
// bytes at a time by the QSPI FSM with zero-latency show-ahead data.
// Provides flush, an almost-empty watermark and sticky overflow/underrun.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - tx_stream_fifo_if slave: write port, pop port, status,
//                threshold and error controls
module tx_stream_fifo
   import qspi_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned FIFO_DEPTH = TX_FIFO_DEPTH,
   parameter int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1,
   parameter int unsigned BLVL_W     = $clog2(FIFO_DEPTH) + 3
) (
   input logic             clk,
   input logic             rst_n,
   tx_stream_fifo_if.slave bus
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);

   if (DATA_WIDTH != 32) begin : g_bad_width
      $error("tx_stream_fifo: DATA_WIDTH must be 32");
   end
   if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("tx_stream_fifo: FIFO_DEPTH must be a power of 2, at least 2");
   end

   logic [31:0]       mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW-1:0]     rd_ptr_nx;
   logic [LVL_W-1:0]  count;
   logic [1:0]        rd_off;
   logic              ovf_r;
   logic              unr_r;

   logic [BLVL_W-1:0] byte_level;
   logic [2:0]        sz_b;
   logic [2:0]        new_off;
   logic              full;
   logic              avail;
   logic              pop_ok;
   logic              retire;
   logic              wr_ok;
   logic              ovf_set;
   logic              unr_set;

   always_comb begin
      rd_ptr_nx  = rd_ptr + 1'b1;
      byte_level = BLVL_W'({count, 2'b00}) - BLVL_W'(rd_off);
      sz_b       = size_bytes(bus.tx_size);
      full       = (count == LVL_W'(FIFO_DEPTH));
      avail      = (byte_level >= BLVL_W'(sz_b));
      new_off    = {1'b0, rd_off} + sz_b;
      pop_ok     = bus.tx_ren & avail & ~bus.flush;
      // Offset wraps past 4 exactly when the head word is fully consumed.
      retire     = pop_ok & new_off[2];
      wr_ok      = bus.fifo_tx_we & ~full & ~bus.flush;
      ovf_set    = bus.fifo_tx_we & full & ~bus.flush;
      unr_set    = bus.tx_ren & ~avail & ~bus.flush;
   end

   always_ff @(posedge clk) begin
      if (wr_ok)
         mem[wr_ptr] <= bus.fifo_tx_data[31:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         rd_off <= '0;
      end else if (bus.flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         rd_off <= '0;
      end else begin
         if (wr_ok)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)
            rd_off <= new_off[1:0];
         if (retire)
            rd_ptr <= rd_ptr_nx;
         case ({wr_ok, retire})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // A new error event outranks err_clr in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_r <= 1'b0;
         unr_r <= 1'b0;
      end else begin
         if (ovf_set)
            ovf_r <= 1'b1;
         else if (bus.err_clr)
            ovf_r <= 1'b0;
         if (unr_set)
            unr_r <= 1'b1;
         else if (bus.err_clr)
            unr_r <= 1'b0;
      end
   end

   logic [31:0] window;

   tx_byte_unpack #(.BLVL_W(BLVL_W)) u_unpack (
      .head_word  (mem[rd_ptr]),
      .next_word  (mem[rd_ptr_nx]),
      .rd_off     (rd_off),
      .nbytes     (sz_b),
      .byte_level (byte_level),
      .data       (window)
   );

   always_comb begin
      bus.tx_data         = DATA_WIDTH'(window);
      bus.tx_avail        = avail;
      bus.tx_empty        = (byte_level == '0);
      bus.tx_full         = full;
      bus.tx_level        = count;
      bus.tx_byte_level   = byte_level;
      bus.tx_almost_empty = (byte_level <= bus.ae_thresh);
      bus.overflow        = ovf_r;
      bus.underrun        = unr_r;
   end

endmodule

// File: tb/tb_tx_stream_fifo.sv
// Directed bench for tx_stream_fifo with hand-computed expectations.
module tb_tx_stream_fifo;
   import qspi_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int unsigned n_checks = 0;
   int unsigned n_pass = 0;

   tx_stream_fifo_if #(.DATA_WIDTH(32), .FIFO_DEPTH(16)) bus ();

   tx_stream_fifo #(.DATA_WIDTH(32), .FIFO_DEPTH(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   // One clock with the given strobes; strobes drop afterwards, tx_size is kept.
   task automatic cyc(input logic we, input logic [31:0] wd, input logic ren,
                      input logic [1:0] sz, input logic fl, input logic ec);
      bus.fifo_tx_we   = we;
      bus.fifo_tx_data = wd;
      bus.tx_ren       = ren;
      bus.tx_size      = sz;
      bus.flush        = fl;
      bus.err_clr      = ec;
      @(posedge clk);
      #1;
      bus.fifo_tx_we = 1'b0;
      bus.tx_ren     = 1'b0;
      bus.flush      = 1'b0;
      bus.err_clr    = 1'b0;
   endtask

   task automatic wr(input logic [31:0] d);
      cyc(1'b1, d, 1'b0, bus.tx_size, 1'b0, 1'b0);
   endtask

   task automatic pop(input logic [1:0] sz);
      cyc(1'b0, '0, 1'b1, sz, 1'b0, 1'b0);
   endtask

   task automatic set_size(input logic [1:0] sz);
      bus.tx_size = sz;
      #1;
   endtask

   initial begin
      bus.fifo_tx_we   = 1'b0;
      bus.fifo_tx_data = '0;
      bus.flush        = 1'b0;
      bus.tx_ren       = 1'b0;
      bus.tx_size      = SZ_1B;
      bus.ae_thresh    = '0;
      bus.err_clr      = 1'b0;

      // Reset
      repeat (2) @(posedge clk);
      #1;
      check("rst_empty", 32'(bus.tx_empty), 32'd1);
      check("rst_ae", 32'(bus.tx_almost_empty), 32'd1);
      check("rst_data", bus.tx_data, 32'h0);
      check("rst_avail", 32'(bus.tx_avail), 32'd0);
      check("rst_ovf", 32'(bus.overflow), 32'd0);
      check("rst_unr", 32'(bus.underrun), 32'd0);
      check("rst_level", 32'(bus.tx_level), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Byte-by-byte pops
      wr(32'h44332211);
      wr(32'h88776655);
      check("t1_level", 32'(bus.tx_level), 32'd2);
      check("t1_blevel", 32'(bus.tx_byte_level), 32'd8);
      set_size(SZ_1B);
      check("t1_b0", bus.tx_data, 32'h11);
      pop(SZ_1B);
      check("t1_b1", bus.tx_data, 32'h22);
      pop(SZ_1B);
      check("t1_b2", bus.tx_data, 32'h33);
      pop(SZ_1B);
      check("t1_b3", bus.tx_data, 32'h44);
      check("t1_level3", 32'(bus.tx_level), 32'd2);
      pop(SZ_1B);
      check("t1_level4", 32'(bus.tx_level), 32'd1);
      check("t1_blevel4", 32'(bus.tx_byte_level), 32'd4);
      check("t1_next", bus.tx_data, 32'h55);

      // Straddling 4-byte pop
      cyc(1'b0, '0, 1'b0, SZ_1B, 1'b1, 1'b0);
      check("t2_flush_empty", 32'(bus.tx_empty), 32'd1);
      wr(32'h44332211);
      wr(32'h88776655);
      check("t2_b0", bus.tx_data, 32'h11);
      pop(SZ_1B);
      set_size(SZ_4B);
      check("t2_w", bus.tx_data, 32'h55443322);
      pop(SZ_4B);
      check("t2_level", 32'(bus.tx_level), 32'd1);
      check("t2_blevel", 32'(bus.tx_byte_level), 32'd3);
      check("t2_avail4", 32'(bus.tx_avail), 32'd0);
      check("t2_tail", bus.tx_data, 32'h00887766);
      set_size(SZ_RSV);
      check("t2_avail_rsv", 32'(bus.tx_avail), 32'd0);

      // Overflow
      cyc(1'b0, '0, 1'b0, SZ_4B, 1'b1, 1'b0);
      for (int i = 0; i < 16; i++) wr(32'h10000000 + 32'(i));
      check("t3_full", 32'(bus.tx_full), 32'd1);
      check("t3_level", 32'(bus.tx_level), 32'd16);
      check("t3_blevel", 32'(bus.tx_byte_level), 32'd64);
      check("t3_ovf_pre", 32'(bus.overflow), 32'd0);
      wr(32'hDEADBEEF);
      check("t3_ovf", 32'(bus.overflow), 32'd1);
      check("t3_level17", 32'(bus.tx_level), 32'd16);
      for (int i = 0; i < 16; i++) begin
         check($sformatf("t3_drain%0d", i), bus.tx_data, 32'h10000000 + 32'(i));
         pop(SZ_4B);
      end
      check("t3_empty", 32'(bus.tx_empty), 32'd1);
      cyc(1'b0, '0, 1'b0, SZ_4B, 1'b0, 1'b1);
      check("t3_ovf_clr", 32'(bus.overflow), 32'd0);

      // Underrun
      pop(SZ_2B);
      check("t4_unr", 32'(bus.underrun), 32'd1);
      check("t4_blevel", 32'(bus.tx_byte_level), 32'd0);
      check("t4_level", 32'(bus.tx_level), 32'd0);
      cyc(1'b0, '0, 1'b0, SZ_1B, 1'b0, 1'b1);
      check("t4_unr_clr", 32'(bus.underrun), 32'd0);
      wr(32'hA1B2C3D4);
      pop(SZ_1B);
      pop(SZ_1B);
      pop(SZ_1B);
      check("t4_blevel3", 32'(bus.tx_byte_level), 32'd1);
      set_size(SZ_2B);
      check("t4_avail", 32'(bus.tx_avail), 32'd0);
      check("t4_data", bus.tx_data, 32'h000000A1);
      pop(SZ_2B);
      check("t4_unr2", 32'(bus.underrun), 32'd1);
      check("t4_blevel_kept", 32'(bus.tx_byte_level), 32'd1);
      check("t4_level_kept", 32'(bus.tx_level), 32'd1);
      cyc(1'b0, '0, 1'b0, SZ_2B, 1'b0, 1'b1);

      // Full + write + retiring pop; flush + write
      cyc(1'b0, '0, 1'b0, SZ_4B, 1'b1, 1'b0);
      for (int i = 0; i < 16; i++) wr(32'h20000000 + 32'(i));
      cyc(1'b1, 32'hCAFEF00D, 1'b1, SZ_4B, 1'b0, 1'b0);
      check("t5_ovf", 32'(bus.overflow), 32'd1);
      check("t5_level", 32'(bus.tx_level), 32'd15);
      check("t5_full", 32'(bus.tx_full), 32'd0);
      check("t5_head", bus.tx_data, 32'h20000001);
      wr(32'h30000000);
      cyc(1'b0, '0, 1'b0, SZ_4B, 1'b0, 1'b1);
      check("t5_full2", 32'(bus.tx_full), 32'd1);
      check("t5_ovf_clr", 32'(bus.overflow), 32'd0);
      cyc(1'b1, 32'h55555555, 1'b1, SZ_4B, 1'b1, 1'b0);
      check("t5_fl_empty", 32'(bus.tx_empty), 32'd1);
      check("t5_fl_level", 32'(bus.tx_level), 32'd0);
      check("t5_fl_ovf", 32'(bus.overflow), 32'd0);
      check("t5_fl_unr", 32'(bus.underrun), 32'd0);

      // Almost-empty watermark
      bus.ae_thresh = 7'd5;
      wr(32'h04030201);
      wr(32'h08070605);
      check("t6_ae8", 32'(bus.tx_almost_empty), 32'd0);
      pop(SZ_2B);
      check("t6_blevel6", 32'(bus.tx_byte_level), 32'd6);
      check("t6_ae6", 32'(bus.tx_almost_empty), 32'd0);
      pop(SZ_1B);
      check("t6_blevel5", 32'(bus.tx_byte_level), 32'd5);
      check("t6_ae5", 32'(bus.tx_almost_empty), 32'd1);
      check("t6_data", bus.tx_data, 32'h04);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
